// File: rtl/wired_cdb_pkg.sv
// Shared CDB result types, source/lane constants and the IQ sniff-view builder
// for the wired writeback arbiter.
package wired_cdb_pkg;
  localparam int ROB_RID_W = 6;
  localparam int XLEN      = 32;

  typedef logic [ROB_RID_W-1:0] rob_rid_t;

  typedef struct packed {
    rob_rid_t        rid;
    logic [XLEN-1:0] wdata;
  } pipeline_cdb_t;

  typedef struct packed {
    logic            valid;
    rob_rid_t        rid;
    logic [XLEN-1:0] wdata;
  } pipeline_cdb_data_t;

  localparam int SRC_ALU0  = 0;
  localparam int SRC_ALU1  = 1;
  localparam int SRC_LSU   = 2;
  localparam int SRC_MDU   = 3;
  localparam int CDB_LANES = 2;

  // The sniff valid bit is forced low on idle lanes so stale payloads never wake anything.
  function automatic pipeline_cdb_data_t cdb_to_sniff(input pipeline_cdb_t cdb, input logic valid);
    pipeline_cdb_data_t s;
    s.valid = valid;
    s.rid   = cdb.rid;
    s.wdata = cdb.wdata;
    return s;
  endfunction
endpackage

// File: rtl/wired_cdb_arbiter_if.sv
// FU->CDB writeback bundle: per-source result streams in, two banked CDB lanes out.
interface wired_cdb_arbiter_if
  import wired_cdb_pkg::*;
#(
  parameter int SRC_COUNT = 4
) ();
  pipeline_cdb_t          src_payload_i [SRC_COUNT];
  logic [SRC_COUNT-1:0]   src_valid_i;
  logic [SRC_COUNT-1:0]   src_ready_o;
  pipeline_cdb_t          cdb_o [CDB_LANES];
  logic [CDB_LANES-1:0]   cdb_valid_o;
  pipeline_cdb_data_t     cdb_sniff_o [CDB_LANES];

  modport slave (
    input  src_payload_i,
    input  src_valid_i,
    output src_ready_o,
    output cdb_o,
    output cdb_valid_o,
    output cdb_sniff_o
  );

  modport master (
    output src_payload_i,
    output src_valid_i,
    input  src_ready_o,
    input  cdb_o,
    input  cdb_valid_o,
    input  cdb_sniff_o
  );
endinterface

// File: rtl/wired_cdb_fifo.sv
// Two-entry result FIFO with head pointer and count; ready depends only on
// registered fullness plus flush/reset gating, never on a same-cycle pop.
module wired_cdb_fifo
  import wired_cdb_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  pipeline_cdb_t push_data,
  input  logic          pop,
  output pipeline_cdb_t head,
  output logic          not_empty,
  output logic          ready
);
  pipeline_cdb_t mem [FIFO_DEPTH];
  logic          head_ptr;
  logic          tail_ptr;
  logic [1:0]    count;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full      = (count == 2'(FIFO_DEPTH));
  assign not_empty = (count != 2'd0);
  assign ready     = !full && !flush && rst_n;
  assign tail_ptr  = head_ptr ^ count[0];
  assign head      = mem[head_ptr];
  assign do_push   = push && ready;
  assign do_pop    = pop && not_empty;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      head_ptr <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (do_pop) head_ptr <= ~head_ptr;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage is data only; ready already folds in flush and reset, so no stale write lands.
  always_ff @(posedge clk) begin
    if (do_push) mem[tail_ptr] <= push_data;
  end
endmodule

// File: rtl/wired_cdb_arbiter.sv
// Writeback arbiter: per-source 2-entry FIFOs feed two ROB-bank CDB lanes with fixed
// priority ALU0 > ALU1 > LSU > MDU. Define WIRED_CDB_STARVE_GUARD_EN for starvation promotion.
module wired_cdb_arbiter
  import wired_cdb_pkg::*;
#(
  parameter int SRC_COUNT    = 4,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  wired_cdb_arbiter_if.slave bus
);
  localparam int SRC_W = (SRC_COUNT > 1) ? $clog2(SRC_COUNT) : 1;

  if (FIFO_DEPTH != 2 || SRC_COUNT < 1 || STARVE_LIMIT < 1) begin : g_cfg_check
    $error("wired_cdb_arbiter: FIFO_DEPTH must be 2, SRC_COUNT and STARVE_LIMIT positive");
  end

  pipeline_cdb_t        head_p0 [SRC_COUNT];
  logic [SRC_COUNT-1:0] nonempty_p0;
  logic [SRC_COUNT-1:0] ready_p0;
  logic [SRC_COUNT-1:0] grant_p0;
  logic [SRC_COUNT-1:0] promoted_p0;
  logic [SRC_COUNT-1:0] cand_p0 [CDB_LANES];
  logic [SRC_COUNT-1:0] pick_p0 [CDB_LANES];
  logic [CDB_LANES-1:0] hit_p0;
  logic [SRC_W-1:0]     sel_p0 [CDB_LANES];

  pipeline_cdb_t        cdb_p1 [CDB_LANES];
  logic [CDB_LANES-1:0] vld_p1;

  for (genvar s = 0; s < SRC_COUNT; s++) begin : g_src
    wired_cdb_fifo #(
      .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush_i),
      .push     (bus.src_valid_i[s]),
      .push_data(bus.src_payload_i[s]),
      .pop      (grant_p0[s]),
      .head     (head_p0[s]),
      .not_empty(nonempty_p0[s]),
      .ready    (ready_p0[s])
    );
  end

`ifdef WIRED_CDB_STARVE_GUARD_EN
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

  logic [WAIT_W-1:0] wait_cnt [SRC_COUNT];

  always_ff @(posedge clk) begin
    for (int s = 0; s < SRC_COUNT; s++) begin
      if (!rst_n || flush_i || grant_p0[s]) begin
        wait_cnt[s] <= '0;
      end else if (nonempty_p0[s] && (wait_cnt[s] != WAIT_W'(STARVE_LIMIT))) begin
        wait_cnt[s] <= wait_cnt[s] + WAIT_W'(1);
      end
    end
  end

  always_comb begin
    promoted_p0 = '0;
    for (int s = 0; s < SRC_COUNT; s++) begin
      promoted_p0[s] = (wait_cnt[s] == WAIT_W'(STARVE_LIMIT));
    end
  end
`else
  assign promoted_p0 = '0;
`endif

  // Stage p0: arbitrate FIFO heads per bank; promoted sources form a higher tier.
  always_comb begin
    grant_p0 = '0;
    hit_p0   = '0;
    for (int k = 0; k < CDB_LANES; k++) begin
      cand_p0[k] = '0;
      sel_p0[k]  = '0;
      for (int s = 0; s < SRC_COUNT; s++) begin
        cand_p0[k][s] = nonempty_p0[s] && (head_p0[s].rid[0] == 1'(k));
      end
      pick_p0[k] = (|(cand_p0[k] & promoted_p0)) ? (cand_p0[k] & promoted_p0) : cand_p0[k];
      hit_p0[k]  = |pick_p0[k];
      for (int s = SRC_COUNT - 1; s >= 0; s--) begin
        if (pick_p0[k][s]) sel_p0[k] = SRC_W'(s);
      end
      if (hit_p0[k]) grant_p0[sel_p0[k]] = 1'b1;
    end
  end

  // Stage p1: registered lanes; idle lanes keep their last payload.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= '0;
      for (int k = 0; k < CDB_LANES; k++) cdb_p1[k] <= '0;
    end else if (flush_i) begin
      vld_p1 <= '0;
    end else begin
      for (int k = 0; k < CDB_LANES; k++) begin
        vld_p1[k] <= hit_p0[k];
        if (hit_p0[k]) cdb_p1[k] <= head_p0[sel_p0[k]];
      end
    end
  end

  assign bus.src_ready_o = ready_p0;
  assign bus.cdb_valid_o = vld_p1;

  for (genvar k = 0; k < CDB_LANES; k++) begin : g_lane_out
    assign bus.cdb_o[k]       = cdb_p1[k];
    assign bus.cdb_sniff_o[k] = cdb_to_sniff(cdb_p1[k], vld_p1[k]);
  end
endmodule

// File: tb/tb_wired_cdb_arbiter.sv
// Bench for wired_cdb_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based model of the writeback rules.
module tb_wired_cdb_arbiter;
  import wired_cdb_pkg::*;

  localparam int NSRC  = 4;
  localparam int LIMIT = 8;
`ifdef WIRED_CDB_STARVE_GUARD_EN
  localparam int STARVE_EXP = 9;
`else
  localparam int STARVE_EXP = -1;
`endif

  logic clk;
  logic rst_n;
  logic flush;
  int   n_tests;
  int   n_fail;
  int   seq;

  wired_cdb_arbiter_if #(.SRC_COUNT(NSRC)) bus ();

  wired_cdb_arbiter #(
    .SRC_COUNT   (NSRC),
    .FIFO_DEPTH  (2),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush_i(flush),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one queue per source, lane outputs, wait ages.
  pipeline_cdb_t mq [NSRC][$];
  logic [1:0]    m_valid;
  pipeline_cdb_t m_cdb [2];
  int            m_wait [NSRC];

  function automatic logic [NSRC-1:0] model_ready();
    logic [NSRC-1:0] r;
    for (int s = 0; s < NSRC; s++) r[s] = (mq[s].size() < 2) && !flush && rst_n;
    return r;
  endfunction

  task automatic drive(input int s, input bit v, input int rid);
    pipeline_cdb_t p;
    p.rid   = rob_rid_t'(rid);
    p.wdata = {8'(s), 24'(seq)};
    seq++;
    bus.src_valid_i[s]   = v;
    bus.src_payload_i[s] = p;
  endtask

  task automatic idle();
    for (int s = 0; s < NSRC; s++) bus.src_valid_i[s] = 1'b0;
  endtask

  // One clock: sample inputs, advance the model by the writeback rules, settle.
  task automatic tick();
    logic [NSRC-1:0] rdy;
    logic [NSRC-1:0] vld;
    pipeline_cdb_t   pl [NSRC];
    int              win [2];
    int              best;
    int              rank;
    rdy = model_ready();
    vld = bus.src_valid_i;
    for (int s = 0; s < NSRC; s++) pl[s] = bus.src_payload_i[s];
    for (int k = 0; k < 2; k++) begin
      win[k] = -1;
      best   = 1000;
      for (int s = 0; s < NSRC; s++) begin
        if (mq[s].size() > 0 && int'(mq[s][0].rid[0]) == k) begin
          rank = s + NSRC;
`ifdef WIRED_CDB_STARVE_GUARD_EN
          if (m_wait[s] >= LIMIT) rank = s;
`endif
          if (rank < best) begin
            best   = rank;
            win[k] = s;
          end
        end
      end
    end
    @(posedge clk);
    if (!rst_n) begin
      for (int s = 0; s < NSRC; s++) begin
        mq[s].delete();
        m_wait[s] = 0;
      end
      m_valid  = 2'b00;
      m_cdb[0] = '0;
      m_cdb[1] = '0;
    end else if (flush) begin
      for (int s = 0; s < NSRC; s++) begin
        mq[s].delete();
        m_wait[s] = 0;
      end
      m_valid = 2'b00;
    end else begin
      for (int s = 0; s < NSRC; s++) begin
        if (win[0] == s || win[1] == s) m_wait[s] = 0;
        else if (mq[s].size() > 0 && m_wait[s] < LIMIT) m_wait[s]++;
      end
      for (int k = 0; k < 2; k++) begin
        if (win[k] >= 0) begin
          m_cdb[k]   = mq[win[k]].pop_front();
          m_valid[k] = 1'b1;
        end else begin
          m_valid[k] = 1'b0;
        end
      end
      for (int s = 0; s < NSRC; s++) if (vld[s] && rdy[s]) mq[s].push_back(pl[s]);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    idle();
    #1;
    n_tests++;
    if (bus.src_ready_o !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ready got=%b exp=0000", bus.src_ready_o);
    end
    tick();
    tick();
    n_tests++;
    if (bus.cdb_valid_o !== 2'b00) begin
      n_fail++; $display("FAIL reset_valid got=%b exp=00", bus.cdb_valid_o);
    end
    n_tests++;
    if (bus.cdb_o[0] !== '0 || bus.cdb_o[1] !== '0) begin
      n_fail++; $display("FAIL reset_cdb got=%h/%h exp=0", bus.cdb_o[0], bus.cdb_o[1]);
    end
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (bus.src_ready_o !== 4'b1111) begin
      n_fail++; $display("FAIL reset_release_ready got=%b exp=1111", bus.src_ready_o);
    end
  endtask

  task automatic test_dual_lane();
    idle();
    drive(0, 1'b1, 4);
    drive(1, 1'b1, 7);
    tick();
    idle();
    n_tests++;
    if (bus.cdb_valid_o !== 2'b00) begin
      n_fail++; $display("FAIL dual_early_valid got=%b exp=00", bus.cdb_valid_o);
    end
    tick();
    n_tests++;
    if (bus.cdb_valid_o !== 2'b11) begin
      n_fail++; $display("FAIL dual_valid got=%b exp=11", bus.cdb_valid_o);
    end
    n_tests++;
    if (bus.cdb_o[0].rid !== 6'd4 || bus.cdb_o[1].rid !== 6'd7) begin
      n_fail++; $display("FAIL dual_rids got=%0d/%0d exp=4/7", bus.cdb_o[0].rid, bus.cdb_o[1].rid);
    end
    n_tests++;
    if (bus.cdb_sniff_o[0].valid !== 1'b1 || bus.cdb_sniff_o[1].rid !== 6'd7) begin
      n_fail++; $display("FAIL dual_sniff got=%b/%0d exp=1/7", bus.cdb_sniff_o[0].valid, bus.cdb_sniff_o[1].rid);
    end
    tick();
    n_tests++;
    if (bus.cdb_valid_o !== 2'b00 || bus.cdb_o[0].rid !== 6'd4 || bus.cdb_sniff_o[0].valid !== 1'b0) begin
      n_fail++; $display("FAIL idle_hold got=%b/%0d/%b exp=00/4/0", bus.cdb_valid_o, bus.cdb_o[0].rid, bus.cdb_sniff_o[0].valid);
    end
  endtask

  task automatic test_bank_conflict();
    idle();
    drive(0, 1'b1, 2);
    drive(2, 1'b1, 6);
    tick();
    idle();
    tick();
    n_tests++;
    if (bus.cdb_valid_o !== 2'b01 || bus.cdb_o[0].rid !== 6'd2) begin
      n_fail++; $display("FAIL conflict_first got=%b/%0d exp=01/2", bus.cdb_valid_o, bus.cdb_o[0].rid);
    end
    tick();
    n_tests++;
    if (bus.cdb_valid_o !== 2'b01 || bus.cdb_o[0].rid !== 6'd6 || bus.cdb_o[0].wdata[31:24] !== 8'd2) begin
      n_fail++; $display("FAIL conflict_second got=%b/%0d exp=01/6", bus.cdb_valid_o, bus.cdb_o[0].rid);
    end
    tick();
    n_tests++;
    if (bus.cdb_valid_o !== 2'b00) begin
      n_fail++; $display("FAIL conflict_drain got=%b exp=00", bus.cdb_valid_o);
    end
  endtask

  task automatic test_backpressure();
    int   mdu_rids [3];
    int   m_idx;
    int   a_rid;
    logic a_acc;
    logic m_acc;
    mdu_rids = '{8, 10, 12};
    m_idx = 0;
    a_rid = 0;
    idle();
    drive(0, 1'b1, a_rid);
    drive(3, 1'b1, mdu_rids[0]);
    for (int i = 0; i < 8; i++) begin
      #1;
      a_acc = bus.src_valid_i[0] & bus.src_ready_o[0];
      m_acc = bus.src_valid_i[3] & bus.src_ready_o[3];
      tick();
      if (a_acc) begin
        a_rid = (a_rid + 2) % 64;
        drive(0, 1'b1, a_rid);
      end
      if (m_acc) begin
        m_idx++;
        if (m_idx < 3) drive(3, 1'b1, mdu_rids[m_idx]);
      end
      if (i >= 1) begin
        n_tests++;
        if (bus.cdb_valid_o[0] !== 1'b1 || bus.cdb_o[0].wdata[31:24] !== 8'd0) begin
          n_fail++; $display("FAIL bp_lane0_alu0 cyc=%0d got=%b/src%0d exp=1/src0", i, bus.cdb_valid_o[0], bus.cdb_o[0].wdata[31:24]);
        end
      end
    end
    #1;
    n_tests++;
    if (m_idx !== 2) begin
      n_fail++; $display("FAIL bp_mdu_accepted got=%0d exp=2", m_idx);
    end
    n_tests++;
    if (bus.src_ready_o[3] !== 1'b0) begin
      n_fail++; $display("FAIL bp_mdu_ready got=%b exp=0", bus.src_ready_o[3]);
    end
    idle();
    repeat (6) tick();
  endtask

  task automatic test_flush();
    idle();
    drive(0, 1'b1, 1);
    drive(1, 1'b1, 3);
    tick();
    drive(0, 1'b1, 5);
    drive(1, 1'b1, 9);
    tick();
    idle();
    drive(2, 1'b1, 10);
    #1;
    n_tests++;
    if (bus.src_ready_o[1] !== 1'b0) begin
      n_fail++; $display("FAIL flush_alu1_full got=%b exp=0", bus.src_ready_o[1]);
    end
    tick();
    idle();
    flush = 1'b1;
    #1;
    n_tests++;
    if (bus.src_ready_o !== 4'b0000) begin
      n_fail++; $display("FAIL flush_ready_gate got=%b exp=0000", bus.src_ready_o);
    end
    tick();
    flush = 1'b0;
    #1;
    n_tests++;
    if (bus.cdb_valid_o !== 2'b00 || bus.src_ready_o !== 4'b1111) begin
      n_fail++; $display("FAIL flush_after got=%b/%b exp=00/1111", bus.cdb_valid_o, bus.src_ready_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (bus.cdb_valid_o !== 2'b00) begin
        n_fail++; $display("FAIL flush_stale cyc=%0d got=%b exp=00", i, bus.cdb_valid_o);
      end
    end
  endtask

  task automatic test_reset_mid();
    idle();
    drive(0, 1'b1, 1);
    drive(3, 1'b1, 3);
    tick();
    drive(0, 1'b1, 5);
    drive(3, 1'b1, 7);
    tick();
    idle();
    #1;
    n_tests++;
    if (bus.src_ready_o[3] !== 1'b0 || bus.cdb_valid_o !== 2'b10) begin
      n_fail++; $display("FAIL rstmid_setup got=%b/%b exp=0/10", bus.src_ready_o[3], bus.cdb_valid_o);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.src_ready_o !== 4'b0000) begin
      n_fail++; $display("FAIL rstmid_ready got=%b exp=0000", bus.src_ready_o);
    end
    tick();
    n_tests++;
    if (bus.cdb_valid_o !== 2'b00 || bus.cdb_o[1] !== '0) begin
      n_fail++; $display("FAIL rstmid_lanes got=%b/%h exp=00/0", bus.cdb_valid_o, bus.cdb_o[1]);
    end
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (bus.src_ready_o !== 4'b1111) begin
      n_fail++; $display("FAIL rstmid_release got=%b exp=1111", bus.src_ready_o);
    end
    tick();
    tick();
    n_tests++;
    if (bus.cdb_valid_o !== 2'b00) begin
      n_fail++; $display("FAIL rstmid_discard got=%b exp=00", bus.cdb_valid_o);
    end
  endtask

  task automatic test_starve();
    int   first_mdu;
    int   a_rid;
    logic a_acc;
    first_mdu = -1;
    a_rid = 0;
    idle();
    drive(0, 1'b1, a_rid);
    drive(3, 1'b1, 0);
    for (int i = 0; i < 20; i++) begin
      #1;
      a_acc = bus.src_valid_i[0] & bus.src_ready_o[0];
      tick();
      if (i == 0) bus.src_valid_i[3] = 1'b0;
      if (a_acc) begin
        a_rid = (a_rid + 2) % 64;
        drive(0, 1'b1, a_rid);
      end
      if (first_mdu < 0 && bus.cdb_valid_o[0] === 1'b1 && bus.cdb_o[0].wdata[31:24] === 8'd3) first_mdu = i;
    end
    n_tests++;
    if (first_mdu !== STARVE_EXP) begin
      n_fail++; $display("FAIL starve_grant_cycle got=%0d exp=%0d", first_mdu, STARVE_EXP);
    end
    idle();
    repeat (5) tick();
  endtask

  task automatic test_random();
    logic [NSRC-1:0]    hold;
    pipeline_cdb_data_t e;
    hold = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int s = 0; s < NSRC; s++) begin
        if (!hold[s]) begin
          if ($urandom_range(0, 99) < 55) drive(s, 1'b1, int'($urandom_range(0, 63)));
          else drive(s, 1'b0, 0);
        end
      end
      flush = ($urandom_range(0, 29) == 0);
      rst_n = ($urandom_range(0, 149) != 0);
      #1;
      n_tests++;
      if (bus.src_ready_o !== model_ready()) begin
        n_fail++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, bus.src_ready_o, model_ready());
      end
      hold = bus.src_valid_i & ~bus.src_ready_o;
      tick();
      n_tests++;
      if (bus.cdb_valid_o !== m_valid) begin
        n_fail++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, bus.cdb_valid_o, m_valid);
      end
      for (int k = 0; k < 2; k++) begin
        e.valid = m_valid[k];
        e.rid   = m_cdb[k].rid;
        e.wdata = m_cdb[k].wdata;
        n_tests++;
        if (bus.cdb_o[k] !== m_cdb[k]) begin
          n_fail++; $display("FAIL rand_cdb%0d cyc=%0d got=%h exp=%h", k, cyc, bus.cdb_o[k], m_cdb[k]);
        end
        n_tests++;
        if (bus.cdb_sniff_o[k] !== e) begin
          n_fail++; $display("FAIL rand_sniff%0d cyc=%0d got=%h exp=%h", k, cyc, bus.cdb_sniff_o[k], e);
        end
      end
    end
    flush = 1'b0;
    rst_n = 1'b1;
    idle();
    repeat (4) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    seq     = 0;
    rst_n   = 1'b0;
    flush   = 1'b0;
    idle();
    test_reset();
    test_dual_lane();
    test_bank_conflict();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_starve();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
